// File: rtl/sync_fifo16.sv
// Single-clock FIFO: register-array storage, wrapping read/write pointers,
// registered data output, registered flags and one-cycle error pulses.
module sync_fifo16 #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_acc;
    logic                  rd_acc;

    // Accept decisions use the registered flags, so a full FIFO never
    // writes into the slot a same-cycle read is freeing, and an empty FIFO
    // never forwards same-cycle write data to dout.
    always_comb begin
        wr_acc      = wr_en && !full_q;
        rd_acc      = rd_en && !empty_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        dout_d      = dout_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            dout_d   = mem[rd_ptr_q];
        end

        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_WIDTH'(1);
            2'b01:   count_d = count_q - CNT_WIDTH'(1);
            default: count_d = count_q;
        endcase

        full_d      = (count_d == CNT_FULL);
        empty_d     = (count_d == CNT_WIDTH'(0));
        overflow_d  = wr_en && full_q;
        underflow_d = rd_en && empty_q;
    end

    // Control and output registers, cleared asynchronously.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dout_q      <= dout_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; left unreset so it can map onto RAM.
    always_ff @(posedge clock) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= din;
        end
    end

    assign dout      = dout_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo16.sv
// Directed bench for sync_fifo16: reset, fill/overflow, drain/underflow,
// steady simultaneous traffic across wrap, boundary simultaneity, mid-run reset.
module tb_sync_fifo16;

    logic        clock;
    logic        rst;
    logic        wr_en;
    logic [15:0] din;
    logic        rd_en;
    logic [15:0] dout;
    logic        full;
    logic        empty;
    logic [4:0]  count;
    logic        overflow;
    logic        underflow;

    int          n_checks;
    int          n_fail;
    logic [15:0] q[$];
    logic [15:0] last;

    sync_fifo16 dut (
        .clock     (clock),
        .rst       (rst),
        .wr_en     (wr_en),
        .din       (din),
        .rd_en     (rd_en),
        .dout      (dout),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Apply inputs, take one rising edge, sample 1 ns later.
    task automatic cycle(input logic w, input logic r, input logic [15:0] d);
        wr_en = w;
        rd_en = r;
        din   = d;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
        #100;
        n_checks++;
        if ({count, full, empty, overflow, underflow} !== {5'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_flags: got cnt=%0d f=%b e=%b ov=%b un=%b, want cnt=0 f=0 e=1 ov=0 un=0",
                     count, full, empty, overflow, underflow);
        end
        n_checks++;
        if (dout !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_dout: got %h want 0000", dout);
        end
        @(negedge clock);
        rst = 1'b1;
    endtask

    task automatic test_fill_overflow();
        logic [15:0] d;
        logic [4:0]  ec;
        logic        ef, eo;
        for (int i = 1; i <= 25; i++) begin
            d = 16'hA000 + 16'(i);
            cycle(1'b1, 1'b0, d);
            if (i <= 16) q.push_back(d);
            ec = (i >= 16) ? 5'd16 : 5'(i);
            ef = (i >= 16);
            eo = (i >= 17);
            n_checks++;
            if ({count, full, empty, overflow, underflow} !== {ec, ef, 1'b0, eo, 1'b0}) begin
                n_fail++;
                $display("FAIL fill[%0d]: got cnt=%0d f=%b e=%b ov=%b un=%b, want cnt=%0d f=%b e=0 ov=%b un=0",
                         i, count, full, empty, overflow, underflow, ec, ef, eo);
            end
        end
    endtask

    task automatic test_drain_underflow();
        logic [4:0] ec;
        logic       ee, eu;
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b0, 1'b1, 16'h0000);
            if (i <= 16) last = q.pop_front();
            ec = (i <= 16) ? 5'(16 - i) : 5'd0;
            ee = (i >= 16);
            eu = (i >= 17);
            n_checks++;
            if (dout !== last) begin
                n_fail++;
                $display("FAIL drain_dout[%0d]: got %h want %h", i, dout, last);
            end
            n_checks++;
            if ({count, full, empty, overflow, underflow} !== {ec, 1'b0, ee, 1'b0, eu}) begin
                n_fail++;
                $display("FAIL drain[%0d]: got cnt=%0d f=%b e=%b ov=%b un=%b, want cnt=%0d f=0 e=%b ov=0 un=%b",
                         i, count, full, empty, overflow, underflow, ec, ee, eu);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [15:0] d;
        for (int k = 0; k < 5; k++) begin
            d = 16'h5000 + 16'(k);
            cycle(1'b1, 1'b0, d);
            q.push_back(d);
        end
        for (int k = 0; k < 40; k++) begin
            d = 16'h6000 + 16'(k);
            cycle(1'b1, 1'b1, d);
            q.push_back(d);
            last = q.pop_front();
            n_checks++;
            if (dout !== last) begin
                n_fail++;
                $display("FAIL simul_dout[%0d]: got %h want %h", k, dout, last);
            end
            n_checks++;
            if ({count, full, empty, overflow, underflow} !== {5'd5, 1'b0, 1'b0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL simul[%0d]: got cnt=%0d f=%b e=%b ov=%b un=%b, want cnt=5 f=0 e=0 ov=0 un=0",
                         k, count, full, empty, overflow, underflow);
            end
        end
    endtask

    task automatic test_back_to_back_boundary();
        logic [15:0] d;
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b1, 16'h0000);
            last = q.pop_front();
            n_checks++;
            if (dout !== last) begin
                n_fail++;
                $display("FAIL bnd_drain[%0d]: got %h want %h", k, dout, last);
            end
        end
        // Empty: write accepted, read rejected, no read-through.
        cycle(1'b1, 1'b1, 16'hB000);
        q.push_back(16'hB000);
        n_checks++;
        if ({count, full, empty, overflow, underflow} !== {5'd1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL bnd_empty: got cnt=%0d f=%b e=%b ov=%b un=%b, want cnt=1 f=0 e=0 ov=0 un=1",
                     count, full, empty, overflow, underflow);
        end
        n_checks++;
        if (dout !== last) begin
            n_fail++;
            $display("FAIL bnd_empty_dout: got %h want %h", dout, last);
        end
        for (int k = 0; k < 15; k++) begin
            d = 16'hC000 + 16'(k);
            cycle(1'b1, 1'b0, d);
            q.push_back(d);
        end
        n_checks++;
        if ({count, full} !== {5'd16, 1'b1}) begin
            n_fail++;
            $display("FAIL bnd_fill: got cnt=%0d f=%b, want cnt=16 f=1", count, full);
        end
        // Full: read accepted, write rejected.
        cycle(1'b1, 1'b1, 16'hDEAD);
        last = q.pop_front();
        n_checks++;
        if ({count, full, empty, overflow, underflow} !== {5'd15, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL bnd_full: got cnt=%0d f=%b e=%b ov=%b un=%b, want cnt=15 f=0 e=0 ov=1 un=0",
                     count, full, empty, overflow, underflow);
        end
        n_checks++;
        if (dout !== last) begin
            n_fail++;
            $display("FAIL bnd_full_dout: got %h want %h", dout, last);
        end
        cycle(1'b0, 1'b0, 16'h0000);
        n_checks++;
        if ({count, overflow, underflow} !== {5'd15, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL bnd_pulse_end: got cnt=%0d ov=%b un=%b, want cnt=15 ov=0 un=0",
                     count, overflow, underflow);
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 6; k++) begin
            cycle(1'b0, 1'b1, 16'h0000);
            last = q.pop_front();
        end
        n_checks++;
        if (count !== 5'd9) begin
            n_fail++;
            $display("FAIL mid_pre_count: got %0d want 9", count);
        end
        #3;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({count, full, empty, overflow, underflow} !== {5'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset: got cnt=%0d f=%b e=%b ov=%b un=%b, want cnt=0 f=0 e=1 ov=0 un=0",
                     count, full, empty, overflow, underflow);
        end
        n_checks++;
        if (dout !== 16'h0000) begin
            n_fail++;
            $display("FAIL mid_reset_dout: got %h want 0000", dout);
        end
        q.delete();
        @(negedge clock);
        rst = 1'b1;
        cycle(1'b1, 1'b0, 16'h1234);
        cycle(1'b1, 1'b0, 16'h5678);
        n_checks++;
        if ({count, empty} !== {5'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_post_count: got cnt=%0d e=%b want cnt=2 e=0", count, empty);
        end
        cycle(1'b0, 1'b1, 16'h0000);
        n_checks++;
        if (dout !== 16'h1234) begin
            n_fail++;
            $display("FAIL mid_first_read: got %h want 1234", dout);
        end
        cycle(1'b0, 1'b1, 16'h0000);
        n_checks++;
        if (dout !== 16'h5678) begin
            n_fail++;
            $display("FAIL mid_second_read: got %h want 5678", dout);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        last     = '0;
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_simultaneous();
        test_back_to_back_boundary();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
